// File: rtl/logic_shift_unit.sv
// Bitwise logic and multi-cycle shift/rotate unit with a valid/ready handshake.
// Shifts walk the operand at most STEP bits per cycle; the result is held in DONE until taken.
module logic_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       logic_function,
    output logic [WIDTH-1:0] logic_output,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOR = 3'b110;
    localparam logic [2:0] OP_ROL = 3'b111;

    localparam logic [CW-1:0]    WIDTH_N = CW'(WIDTH);
    localparam logic [CW-1:0]    STEP_N  = CW'(STEP);
    localparam logic [WIDTH-1:0] WIDTH_Y = WIDTH'(WIDTH);

    logic [1:0]       state;
    logic [2:0]       op;
    logic [CW-1:0]    count;

    logic             is_shift;
    logic [CW-1:0]    load_count;
    logic [WIDTH-1:0] accept_value;
    logic [CW-1:0]    step;
    logic [CW-1:0]    rot_back;
    logic [CW-1:0]    next_count;
    logic [WIDTH-1:0] shifted;

    // The full y is compared against WIDTH before truncation, so large
    // shift amounts saturate instead of wrapping into the small counter.
    always_comb begin
        is_shift     = 1'b0;
        load_count   = '0;
        accept_value = x;
        case (logic_function)
            OP_AND: accept_value = x & y;
            OP_XOR: accept_value = x ^ y;
            OP_OR:  accept_value = x | y;
            OP_NOR: accept_value = ~(x | y);
            OP_SLL, OP_SRL, OP_SRA: begin
                is_shift   = 1'b1;
                load_count = (y >= WIDTH_Y) ? WIDTH_N : CW'(y);
            end
            OP_ROL: begin
                is_shift   = 1'b1;
                load_count = CW'(y % WIDTH_Y);
            end
            default: accept_value = x;
        endcase
    end

    always_comb begin
        step       = (count > STEP_N) ? STEP_N : count;
        rot_back   = WIDTH_N - step;
        next_count = count - step;
        shifted    = logic_output;
        case (op)
            OP_SLL:  shifted = logic_output << step;
            OP_SRL:  shifted = logic_output >> step;
            OP_SRA:  shifted = WIDTH'($signed(logic_output) >>> step);
            OP_ROL:  shifted = (logic_output << step) | (logic_output >> rot_back);
            default: shifted = logic_output;
        endcase
    end

    // logic_output doubles as the shift working register, so zero tracks
    // every write and is correct once the final step lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            op           <= OP_AND;
            count        <= '0;
            logic_output <= '0;
            zero         <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op           <= logic_function;
                        count        <= load_count;
                        logic_output <= accept_value;
                        zero         <= (accept_value == '0);
                        state        <= (is_shift && load_count != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    logic_output <= shifted;
                    zero         <= (shifted == '0);
                    count        <= next_count;
                    if (next_count == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT) || (state == DONE);

endmodule

// File: doc/logic_shift_unit.md
LOGIC_SHIFT_UNIT -- requirements
Module: logic_shift_unit

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits; SHALL be >= 8.
REQ-002 Parameter STEP, 4, maximum shift distance per SHIFT cycle; SHALL be between 1 and WIDTH.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 x  input  WIDTH  operand A, signed for SRA.
REQ-009 y  input  WIDTH  operand B; the full value is the shift amount for shift ops.
REQ-010 logic_function  input  3  000 AND, 001 XOR, 010 SLL, 011 SRL, 100 SRA, 101 OR, 110 NOR, 111 ROL.
REQ-011 logic_output  output  WIDTH  registered result.
REQ-012 zero  output  1  registered; high when logic_output == 0.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 busy  output  1  high in SHIFT or DONE.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-017 A request SHALL be accepted on a rising edge with state IDLE and in_valid=1; x, y and logic_function are sampled only then.
REQ-018 Logic ops (AND, XOR, OR, NOR) SHALL register the result and enter DONE on the accept edge, so out_valid is high 1 cycle after accept.
REQ-019 Shift ops SHALL load the operand and a remaining count n: SLL/SRL/SRA n = min(y, WIDTH); ROL n = y mod WIDTH.
REQ-020 On accept with n = 0, the block SHALL load logic_output = x and enter DONE directly (latency 1).
REQ-021 On accept with n > 0, the block SHALL enter SHIFT.
REQ-022 Each SHIFT cycle SHALL shift the working value by s = min(STEP, n) and set n = n - s.
REQ-023 SLL and SRL SHALL zero-fill, SRA SHALL fill with the current MSB, and ROL SHALL rotate MSBs into the LSBs.
REQ-024 The block SHALL leave SHIFT for DONE on the cycle n reaches 0.
REQ-025 Shift latency from accept to out_valid SHALL be 1 + ceil(n/STEP) cycles.
REQ-026 Saturation: SLL/SRL with y >= WIDTH SHALL give 0; SRA with y >= WIDTH SHALL give all bits equal to x[WIDTH-1].
REQ-027 The count register SHALL be clog2(WIDTH)+1 bits; bits of y above WIDTH SHALL only affect saturation and never wrap.
REQ-028 In DONE, logic_output and zero SHALL hold stable until out_valid && out_ready, then the block SHALL return to IDLE on that edge.
REQ-029 There SHALL be no accept in the same cycle as a DONE release; the next accept is possible 1 cycle later.
REQ-030 in_valid while busy SHALL be ignored, with no queueing.
REQ-031 logic_output SHALL be updated only on the accept edge, in SHIFT, or at reset, never in IDLE.
REQ-032 zero SHALL be computed from the final value written to logic_output.
REQ-033 All logic_function codes are legal; none SHALL produce X or a hang.

Reset
REQ-034 With rst_n=0 at a rising edge, the block SHALL set state=IDLE, n=0, logic_output=0, zero=1, out_valid=0, busy=0 and in_ready=1 on that edge.
REQ-035 Reset SHALL take priority over all other activity; a reset in SHIFT or DONE SHALL discard the operation with no output handshake.
REQ-036 in_valid SHALL be ignored while rst_n=0.

Verification (WIDTH=32, STEP=4)
REQ-037 AND with x=0xF0F0_1234, y=0x0FF0_FFFF, out_ready=1 -> logic_output=0x00F0_1234, zero=0, out_valid 1 cycle after accept for exactly 1 cycle.
REQ-038 SRA with x=0x8000_0000, y=9 -> 0xFFC0_0000 with out_valid 4 cycles after accept; SRL with the same operands -> 0x0040_0000.
REQ-039 SLL with x=0xFFFF_FFFF, y=40 -> 0, zero=1, latency 9; SLL with y=0 -> logic_output=x, latency 1.
REQ-040 ROL with x=0x8000_0001, y=33 -> 0x0000_0003, latency 2.
REQ-041 Backpressure on XOR (x=0xA5A5_A5A5, y=0xFFFF_FFFF): hold out_ready=0 for 5 cycles while toggling in_valid -> result 0x5A5A_5A5A held, in_ready=0, no new accept; the next accept comes 1 cycle after release.
REQ-042 Reset mid-op: SRL y=31, assert rst_n=0 on the 3rd SHIFT cycle -> next cycle IDLE, logic_output=0, zero=1, out_valid never asserted; a following OR 0x1|0x2 -> 0x3.
